reg_wb_scheduler: RTL and testbench

Write-back scheduler for the register file in the multi-cycle core. It shares the register file's single write port between two write-back requesters: the ALU result path and the memory load path. It also keeps a per-register busy scoreboard so the control unit can hold operand reads until outstanding writes land. It sits between the execute/memory stages and `reg_file`, and drives `wr_en`, `wr_reg_index` and `wr_reg_data` directly.

---
 rtl/reg_wb_scheduler_if.sv | 42 ++++
 rtl/reg_wb_scheduler.sv | 93 +++++++++
 tb/tb_reg_wb_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_scheduler_if.sv
// rtl/reg_wb_scheduler_if.sv - requester, scoreboard and register-file write bundle for reg_wb_scheduler
interface reg_wb_scheduler_if #(
   parameter int REGISTER_WIDTH  = 32,
   parameter int REG_INDEX_WIDTH = 5
);
   logic                       alu_req;
   logic [REG_INDEX_WIDTH-1:0] alu_idx;
   logic [REGISTER_WIDTH-1:0]  alu_data;
   logic                       alu_gnt;

   logic                       mem_req;
   logic [REG_INDEX_WIDTH-1:0] mem_idx;
   logic [REGISTER_WIDTH-1:0]  mem_data;
   logic                       mem_gnt;

   logic                       issue_en;
   logic [REG_INDEX_WIDTH-1:0] issue_idx;
   logic [REG_INDEX_WIDTH-1:0] rd_reg_index_1;
   logic [REG_INDEX_WIDTH-1:0] rd_reg_index_2;
   logic                       busy_1;
   logic                       busy_2;

   logic                       wr_en;
   logic [REG_INDEX_WIDTH-1:0] wr_reg_index;
   logic [REGISTER_WIDTH-1:0]  wr_reg_data;

   modport master (
      output alu_req, alu_idx, alu_data,
      output mem_req, mem_idx, mem_data,
      output issue_en, issue_idx, rd_reg_index_1, rd_reg_index_2,
      input  alu_gnt, mem_gnt, busy_1, busy_2,
      input  wr_en, wr_reg_index, wr_reg_data
   );

   modport slave (
      input  alu_req, alu_idx, alu_data,
      input  mem_req, mem_idx, mem_data,
      input  issue_en, issue_idx, rd_reg_index_1, rd_reg_index_2,
      output alu_gnt, mem_gnt, busy_1, busy_2,
      output wr_en, wr_reg_index, wr_reg_data
   );
endinterface

// File: rtl/reg_wb_scheduler.sv
// rtl/reg_wb_scheduler.sv - round-robin write-back arbiter for the register file write port with busy scoreboard
module reg_wb_scheduler #(
   parameter int REGISTER_WIDTH  = 32,
   parameter int REG_INDEX_WIDTH = 5,
   parameter int REGISTER_COUNT  = 32
) (
   input logic              clk,
   input logic              rst,
   reg_wb_scheduler_if.slave bus
);
   typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

   src_e                        last_q, last_d;
   logic                        alu_gnt, mem_gnt, any_gnt;
   logic [REG_INDEX_WIDTH-1:0]  sel_idx;
   logic [REGISTER_WIDTH-1:0]   sel_data;

   logic                        wr_en_q, wr_en_d;
   logic [REG_INDEX_WIDTH-1:0]  wr_idx_q, wr_idx_d;
   logic [REGISTER_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic [REGISTER_COUNT-1:0]   busy_q, busy_d;

   // Indices beyond REGISTER_COUNT read as not busy instead of indexing out of range.
   function automatic logic busy_lookup(input logic [REGISTER_COUNT-1:0]  vec,
                                        input logic [REG_INDEX_WIDTH-1:0] idx);
      busy_lookup = 1'b0;
      for (int i = 0; i < REGISTER_COUNT; i++) begin
         if (idx == REG_INDEX_WIDTH'(i)) busy_lookup = vec[i];
      end
   endfunction

   always_comb begin
      alu_gnt = 1'b0;
      mem_gnt = 1'b0;
      if (!rst) begin
         if (bus.alu_req && bus.mem_req) begin
            if (last_q == SRC_MEM) alu_gnt = 1'b1;
            else                   mem_gnt = 1'b1;
         end else begin
            alu_gnt = bus.alu_req;
            mem_gnt = bus.mem_req;
         end
      end
      any_gnt  = alu_gnt | mem_gnt;
      sel_idx  = mem_gnt ? bus.mem_idx  : bus.alu_idx;
      sel_data = mem_gnt ? bus.mem_data : bus.alu_data;
   end

   always_comb begin
      last_d = last_q;
      if (alu_gnt)      last_d = SRC_ALU;
      else if (mem_gnt) last_d = SRC_MEM;

      // x0 writes still consume a grant but never reach the register file.
      wr_en_d   = any_gnt && (sel_idx != '0);
      wr_idx_d  = any_gnt ? sel_idx  : wr_idx_q;
      wr_data_d = any_gnt ? sel_data : wr_data_q;

      busy_d = busy_q;
      for (int i = 0; i < REGISTER_COUNT; i++) begin
         if (wr_en_q && (wr_idx_q == REG_INDEX_WIDTH'(i))) busy_d[i] = 1'b0;
      end
      for (int i = 0; i < REGISTER_COUNT; i++) begin
         if (bus.issue_en && (bus.issue_idx == REG_INDEX_WIDTH'(i))) busy_d[i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q    <= SRC_MEM;
         wr_en_q   <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
         busy_q    <= '0;
      end else begin
         last_q    <= last_d;
         wr_en_q   <= wr_en_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.alu_gnt      = alu_gnt;
   assign bus.mem_gnt      = mem_gnt;
   assign bus.busy_1       = busy_lookup(busy_q, bus.rd_reg_index_1);
   assign bus.busy_2       = busy_lookup(busy_q, bus.rd_reg_index_2);
   // A reset raised while a write sits in the write stage cancels it before reg_file samples on the negedge.
   assign bus.wr_en        = wr_en_q & ~rst;
   assign bus.wr_reg_index = wr_idx_q;
   assign bus.wr_reg_data  = wr_data_q;
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// tb/tb_reg_wb_scheduler.sv - directed and randomized bench for reg_wb_scheduler
module tb_reg_wb_scheduler;
   localparam int DW = 32;
   localparam int IW = 5;
   localparam int RC = 32;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic rf_clr = 1'b1;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   logic [DW-1:0] rf [RC];

   reg_wb_scheduler_if #(.REGISTER_WIDTH(DW), .REG_INDEX_WIDTH(IW)) bus ();

   reg_wb_scheduler #(
      .REGISTER_WIDTH (DW),
      .REG_INDEX_WIDTH(IW),
      .REGISTER_COUNT (RC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Stand-in register file: samples the write port on the negedge.
   always @(negedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < RC; i++) rf[i] <= '0;
      end else if (bus.wr_en) begin
         rf[bus.wr_reg_index] <= bus.wr_reg_data;
      end
   end

   // Reference model state
   logic          m_last;
   logic          m_wr_en;
   logic [IW-1:0] m_wr_idx;
   logic [DW-1:0] m_wr_data;
   bit            m_busy [RC];
   logic          a_pend, m_pend, ea, em, iss;
   logic [IW-1:0] a_idx, mm_idx, iss_idx, r1, r2;
   logic [DW-1:0] a_data, mm_data;
   logic          exp_alu;
   int            a_n, m_n;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.alu_req   = 1'b0;
      bus.alu_idx   = '0;
      bus.alu_data  = '0;
      bus.mem_req   = 1'b0;
      bus.mem_idx   = '0;
      bus.mem_data  = '0;
      bus.issue_en  = 1'b0;
      bus.issue_idx = '0;
   endtask

   initial begin
      idle();
      bus.rd_reg_index_1 = '0;
      bus.rd_reg_index_2 = '0;

      // Reset with requests and an issue pending
      bus.alu_req = 1'b1; bus.alu_idx = 5'd3; bus.alu_data = 32'h1111_1111;
      bus.mem_req = 1'b1; bus.mem_idx = 5'd4; bus.mem_data = 32'h2222_2222;
      bus.issue_en = 1'b1; bus.issue_idx = 5'd3;
      bus.rd_reg_index_1 = 5'd3; bus.rd_reg_index_2 = 5'd4;
      tick();
      tick();
      rf_clr = 1'b0;
      chk("rst_alu_gnt", bus.alu_gnt, 0);
      chk("rst_mem_gnt", bus.mem_gnt, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_wr_idx", bus.wr_reg_index, 0);
      chk("rst_wr_data", bus.wr_reg_data, 0);
      chk("rst_busy_1", bus.busy_1, 0);
      chk("rst_busy_2", bus.busy_2, 0);

      // Release: ALU wins first contention, then MEM is served
      rst = 1'b0;
      bus.issue_en = 1'b0;
      bus.alu_idx = 5'd0; bus.mem_idx = 5'd0;
      settle();
      chk("first_alu_gnt", bus.alu_gnt, 1);
      chk("first_mem_gnt", bus.mem_gnt, 0);
      tick();
      chk("first_x0_wr_en", bus.wr_en, 0);
      chk("post_rst_busy_1", bus.busy_1, 0);
      bus.alu_req = 1'b0;
      settle();
      chk("mem_after_alu_gnt", bus.mem_gnt, 1);
      tick();
      idle();

      // Single ALU write
      bus.alu_req = 1'b1; bus.alu_idx = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
      settle();
      chk("single_alu_gnt", bus.alu_gnt, 1);
      chk("single_mem_gnt", bus.mem_gnt, 0);
      tick();
      idle();
      chk("single_wr_en", bus.wr_en, 1);
      chk("single_wr_idx", bus.wr_reg_index, 5);
      chk("single_wr_data", bus.wr_reg_data, 32'hDEAD_BEEF);
      @(negedge clk);
      #1;
      chk("single_rf5", rf[5], 32'hDEAD_BEEF);
      tick();
      chk("single_wr_en_low", bus.wr_en, 0);
      chk("single_wr_idx_hold", bus.wr_reg_index, 5);

      // MEM-only x0 write leaves last = MEM
      bus.mem_req = 1'b1; bus.mem_idx = 5'd0; bus.mem_data = 32'h0BAD_0BAD;
      settle();
      chk("mem_x0_gnt", bus.mem_gnt, 1);
      tick();
      idle();
      chk("mem_x0_wr_en", bus.wr_en, 0);

      // Contention: grants alternate ALU, MEM, ALU, MEM
      a_n = 1;
      m_n = 9;
      for (int k = 0; k < 4; k++) begin
         bus.alu_req = 1'b1; bus.alu_idx = IW'(a_n); bus.alu_data = 32'hA000_0000 + DW'(a_n);
         bus.mem_req = 1'b1; bus.mem_idx = IW'(m_n); bus.mem_data = 32'hB000_0000 + DW'(m_n);
         settle();
         exp_alu = (k % 2 == 0);
         chk("cont_alu_gnt", bus.alu_gnt, exp_alu);
         chk("cont_mem_gnt", bus.mem_gnt, !exp_alu);
         tick();
         chk("cont_wr_en", bus.wr_en, 1);
         chk("cont_wr_idx", bus.wr_reg_index, exp_alu ? DW'(a_n) : DW'(m_n));
         chk("cont_wr_data", bus.wr_reg_data,
             exp_alu ? 32'hA000_0000 + DW'(a_n) : 32'hB000_0000 + DW'(m_n));
         if (exp_alu) a_n++;
         else         m_n++;
      end
      idle();
      tick();
      chk("cont_wr_en_done", bus.wr_en, 0);

      // Scoreboard set and clear on index 7
      bus.issue_en = 1'b1; bus.issue_idx = 5'd7; bus.rd_reg_index_1 = 5'd7;
      settle();
      chk("sb_busy_before", bus.busy_1, 0);
      tick();
      bus.issue_en = 1'b0;
      chk("sb_busy_set", bus.busy_1, 1);
      bus.mem_req = 1'b1; bus.mem_idx = 5'd7; bus.mem_data = 32'h0000_0077;
      settle();
      chk("sb_mem_gnt", bus.mem_gnt, 1);
      tick();
      idle();
      chk("sb_wr_en", bus.wr_en, 1);
      chk("sb_wr_idx", bus.wr_reg_index, 7);
      chk("sb_busy_during_wr", bus.busy_1, 1);
      tick();
      chk("sb_busy_cleared", bus.busy_1, 0);
      chk("sb_rf7", rf[7], 32'h0000_0077);

      // Set wins over clear at the same posedge
      bus.issue_en = 1'b1; bus.issue_idx = 5'd7;
      tick();
      bus.issue_en = 1'b0;
      chk("sw_busy_set", bus.busy_1, 1);
      bus.mem_req = 1'b1; bus.mem_idx = 5'd7; bus.mem_data = 32'h0000_0078;
      tick();
      bus.mem_req = 1'b0;
      bus.issue_en = 1'b1; bus.issue_idx = 5'd7;
      chk("sw_wr_en", bus.wr_en, 1);
      tick();
      bus.issue_en = 1'b0;
      chk("sw_busy_kept", bus.busy_1, 1);
      tick();
      chk("sw_busy_still", bus.busy_1, 1);

      // x0 write and x0 issue
      bus.alu_req = 1'b1; bus.alu_idx = 5'd0; bus.alu_data = 32'h0000_1234;
      bus.issue_en = 1'b1; bus.issue_idx = 5'd0;
      bus.rd_reg_index_1 = 5'd0; bus.rd_reg_index_2 = 5'd0;
      settle();
      chk("x0_alu_gnt", bus.alu_gnt, 1);
      tick();
      idle();
      chk("x0_wr_en", bus.wr_en, 0);
      chk("x0_wr_idx", bus.wr_reg_index, 0);
      chk("x0_wr_data", bus.wr_reg_data, 32'h0000_1234);
      chk("x0_busy_1", bus.busy_1, 0);
      chk("x0_busy_2", bus.busy_2, 0);

      // Reset in the write-stage cycle cancels the write
      bus.rd_reg_index_1 = 5'd7; bus.rd_reg_index_2 = 5'd20;
      settle();
      chk("mr_busy7_pre", bus.busy_1, 1);
      bus.alu_req = 1'b1; bus.alu_idx = 5'd20; bus.alu_data = 32'hCAFE_F00D;
      settle();
      chk("mr_alu_gnt", bus.alu_gnt, 1);
      tick();
      bus.alu_idx = 5'd21; bus.alu_data = 32'h0000_0005;
      rst = 1'b1;
      settle();
      chk("mr_wr_en_forced", bus.wr_en, 0);
      chk("mr_no_gnt", bus.alu_gnt, 0);
      tick();
      chk("mr_wr_en", bus.wr_en, 0);
      chk("mr_busy7", bus.busy_1, 0);
      chk("mr_busy20", bus.busy_2, 0);
      chk("mr_rf20", rf[20], 0);
      chk("mr_rf21", rf[21], 0);
      rst = 1'b0;
      idle();
      tick();
      chk("mr_after_wr_en", bus.wr_en, 0);

      // Randomized traffic against the reference model
      m_last    = 1'b1;
      m_wr_en   = 1'b0;
      m_wr_idx  = '0;
      m_wr_data = '0;
      for (int i = 0; i < RC; i++) m_busy[i] = 1'b0;
      a_pend = 1'b0;
      m_pend = 1'b0;
      a_idx = '0; a_data = '0; mm_idx = '0; mm_data = '0;
      for (int c = 0; c < 300; c++) begin
         if (!a_pend && ($urandom_range(0, 2) != 0)) begin
            a_pend = 1'b1;
            a_idx  = IW'($urandom_range(0, RC - 1));
            a_data = $urandom();
         end
         if (!m_pend && ($urandom_range(0, 2) != 0)) begin
            m_pend  = 1'b1;
            mm_idx  = IW'($urandom_range(0, RC - 1));
            mm_data = $urandom();
         end
         iss     = ($urandom_range(0, 2) == 0);
         iss_idx = IW'($urandom_range(0, RC - 1));
         r1      = ($urandom_range(0, 1) == 0) ? iss_idx : IW'($urandom_range(0, RC - 1));
         r2      = ($urandom_range(0, 1) == 0) ? a_idx   : IW'($urandom_range(0, RC - 1));

         bus.alu_req = a_pend; bus.alu_idx = a_idx;  bus.alu_data = a_data;
         bus.mem_req = m_pend; bus.mem_idx = mm_idx; bus.mem_data = mm_data;
         bus.issue_en = iss; bus.issue_idx = iss_idx;
         bus.rd_reg_index_1 = r1; bus.rd_reg_index_2 = r2;
         settle();

         ea = a_pend && (!m_pend || m_last);
         em = m_pend && (!a_pend || !m_last);
         chk("rnd_alu_gnt", bus.alu_gnt, ea);
         chk("rnd_mem_gnt", bus.mem_gnt, em);
         chk("rnd_busy_1", bus.busy_1, m_busy[r1]);
         chk("rnd_busy_2", bus.busy_2, m_busy[r2]);
         chk("rnd_wr_en", bus.wr_en, m_wr_en);
         chk("rnd_wr_idx", bus.wr_reg_index, m_wr_idx);
         chk("rnd_wr_data", bus.wr_reg_data, m_wr_data);

         if (m_wr_en) m_busy[m_wr_idx] = 1'b0;
         if (iss && (iss_idx != 0)) m_busy[iss_idx] = 1'b1;
         if (ea) begin
            m_wr_en = (a_idx != 0); m_wr_idx = a_idx; m_wr_data = a_data;
            m_last = 1'b0; a_pend = 1'b0;
         end else if (em) begin
            m_wr_en = (mm_idx != 0); m_wr_idx = mm_idx; m_wr_data = mm_data;
            m_last = 1'b1; m_pend = 1'b0;
         end else begin
            m_wr_en = 1'b0;
         end
         tick();
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
